// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48A1 dot-product scheduler.
// OPMODE values select X=M with Z=0 (first product) or Z=P (accumulate).
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int         PIPE_LAT  = 3;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_OFF   = 8'h00;

endpackage

// File: rtl/dsp_mac_sched_pipe.sv
// Two-entry valid/first delay line that shadows the slice's M and P register stages.
// Tap 0 enables the M register and tap 1 enables the P register.
module dsp_mac_sched_pipe (
    input  logic clk,
    input  logic rst_n,
    input  logic acc,
    input  logic acc_first,
    output logic ce_m,
    output logic ce_p,
    output logic tap1_first,
    output logic empty
);

    logic vld_p0;
    logic vld_p1;
    logic first_p0;
    logic first_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            first_p0 <= 1'b0;
            first_p1 <= 1'b0;
        end else begin
            // p0: product being registered into M
            vld_p0   <= acc;
            first_p0 <= acc && acc_first;
            // p1: M being folded into P
            vld_p1   <= vld_p0;
            first_p1 <= first_p0;
        end
    end

    assign ce_m       = vld_p0;
    assign ce_p       = vld_p1;
    assign tap1_first = vld_p1 && first_p1;
    assign empty      = !vld_p0 && !vld_p1;

endmodule

// File: rtl/dsp_mac_sched.sv
// Dot-product scheduler driving an external DSP48A1 slice (A/B -> M -> P accumulate).
// Optional: define DSP_MAC_SCHED_STALL_CNT_EN to add the 16-bit stall_cnt output.
module dsp_mac_sched
    import dsp_mac_pkg::*;
#(
    parameter int LEN_WIDTH = 8,
    parameter int AB_WIDTH  = 18
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       len,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [AB_WIDTH-1:0] a_in,
    input  logic signed [AB_WIDTH-1:0] b_in,
    output logic signed [AB_WIDTH-1:0] dsp_a,
    output logic signed [AB_WIDTH-1:0] dsp_b,
    output logic [7:0]                 dsp_opmode,
    output logic                       dsp_ce_ab,
    output logic                       dsp_ce_m,
    output logic                       dsp_ce_p,
    input  logic signed [47:0]         dsp_p,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [47:0]         res_data,
    output logic                       done
`ifdef DSP_MAC_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   acc_cnt;
    logic [LEN_WIDTH-1:0]   cnt_inc;
    logic signed [47:0]     res_q;
    logic                   done_q;
    logic                   start_ok;
    logic                   accept;
    logic                   tap1_first;
    logic                   pipe_empty;

    // The done cycle is spent in IDLE, so a start there must be masked explicitly.
    assign start_ok = start && (state == IDLE) && !done_q;
    assign in_ready = (state == FEED) && (acc_cnt != len_q);
    assign accept   = in_ready && in_valid;
    assign cnt_inc  = acc_cnt + LEN_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_q   <= '0;
            acc_cnt <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        if (len != '0) begin
                            len_q   <= len;
                            acc_cnt <= '0;
                            state   <= FEED;
                        end else begin
                            res_q <= '0;
                            state <= HOLD;
                        end
                    end
                end
                FEED: begin
                    // accept is gated by acc_cnt != len_q, so the counter stops at len
                    if (accept) begin
                        acc_cnt <= cnt_inc;
                        if (cnt_inc == len_q)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        res_q <= dsp_p;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dsp_mac_sched_pipe u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc        (accept),
        .acc_first  (acc_cnt == '0),
        .ce_m       (dsp_ce_m),
        .ce_p       (dsp_ce_p),
        .tap1_first (tap1_first),
        .empty      (pipe_empty)
    );

    assign dsp_ce_ab = accept;
    assign dsp_a     = accept ? a_in : '0;
    assign dsp_b     = accept ? b_in : '0;

    always_comb begin
        dsp_opmode = OPM_OFF;
        if (state == FEED || state == DRAIN)
            dsp_opmode = tap1_first ? OPM_FIRST : OPM_ACC;
    end

    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);
    assign res_data  = res_q;
    assign done      = done_q;

`ifdef DSP_MAC_SCHED_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counts FEED slots that the producer left empty.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (start_ok)
            stall_cnt <= '0;
        else if (in_ready && !in_valid)
            stall_cnt <= sat_inc16(stall_cnt);
    end
`endif

endmodule

// File: tb/tb_dsp_mac_sched.sv
// Directed bench for dsp_mac_sched with a behavioural DSP48A1 A/B -> M -> P slice model.
module tb_dsp_mac_sched;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         len;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] a_in;
    logic signed [17:0] b_in;
    logic signed [17:0] dsp_a;
    logic signed [17:0] dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_ce_ab;
    logic               dsp_ce_m;
    logic               dsp_ce_p;
    logic signed [47:0] dsp_p;
    logic               res_valid;
    logic               res_ready;
    logic signed [47:0] res_data;
    logic               done;
`ifdef DSP_MAC_SCHED_STALL_CNT_EN
    logic [15:0]        stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_ce_ab  = 0;
    int n_ce_m   = 0;
    int n_ce_p   = 0;

    logic signed [17:0] pa [256];
    logic signed [17:0] pb [256];

    always #5 clk = ~clk;

    dsp_mac_sched #(.LEN_WIDTH(8), .AB_WIDTH(18)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_ce_ab  (dsp_ce_ab),
        .dsp_ce_m   (dsp_ce_m),
        .dsp_ce_p   (dsp_ce_p),
        .dsp_p      (dsp_p),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .done       (done)
`ifdef DSP_MAC_SCHED_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Slice model: P starts at junk so a missing first-sample OPMODE shows up.
    logic signed [17:0] m_a = 18'sd0;
    logic signed [17:0] m_b = 18'sd0;
    logic signed [35:0] m_m = 36'sd0;
    logic signed [47:0] m_p = 48'sd1000;

    always @(posedge clk) begin
        if (dsp_ce_ab) begin
            m_a <= dsp_a;
            m_b <= dsp_b;
        end
        if (dsp_ce_m)
            m_m <= m_a * m_b;
        if (dsp_ce_p) begin
            if (dsp_opmode == 8'h01)
                m_p <= {{12{m_m[35]}}, m_m};
            else if (dsp_opmode == 8'h09)
                m_p <= m_p + {{12{m_m[35]}}, m_m};
            else
                m_p <= 48'h0BAD_0BAD_0BAD;
        end
    end
    assign dsp_p = m_p;

    always @(negedge clk) begin
        n_done  <= n_done  + int'(done);
        n_ce_ab <= n_ce_ab + int'(dsp_ce_ab);
        n_ce_m  <= n_ce_m  + int'(dsp_ce_m);
        n_ce_p  <= n_ce_p  + int'(dsp_ce_p);
    end

    task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic start_job(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
        check_eq("busy_after_start", 48'(busy), 48'd1);
    endtask

    task automatic feed(input int n, input int gap);
        int t;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            in_valid = 1'b1;
            a_in     = pa[i];
            b_in     = pb[i];
            #1;
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                #1;
                t++;
            end
            check_eq("in_ready_feed", 48'(in_ready), 48'd1);
            check_eq("ce_ab_on_accept", 48'(dsp_ce_ab), 48'd1);
            check_eq("dsp_a_on_accept", 48'(dsp_a), 48'(pa[i]));
            check_eq("dsp_b_on_accept", 48'(dsp_b), 48'(pb[i]));
            @(negedge clk);
        end
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
    endtask

    // Called on the negedge right after the last accept edge.
    task automatic finish_job(input logic signed [47:0] exp, input int hold, input bit start_in_done);
        int t = 0;
        while (!res_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("result_latency", 48'(t), 48'd3);
        check_eq("res_data", res_data, exp);
`ifdef DSP_MAC_SCHED_STALL_CNT_EN
        if (hold > 0)
            check_eq("stall_cnt", 48'(stall_cnt), 48'd4);
`endif
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            len   = 8'd2;
            @(negedge clk);
            check_eq("hold_res_valid", 48'(res_valid), 48'd1);
            check_eq("hold_res_data", res_data, exp);
            check_eq("hold_no_done", 48'(done), 48'd0);
        end
        start     = 1'b0;
        len       = 8'd0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("done_pulse", 48'(done), 48'd1);
        check_eq("busy_in_done", 48'(busy), 48'd0);
        check_eq("res_valid_in_done", 48'(res_valid), 48'd0);
        if (start_in_done) begin
            start = 1'b1;
            len   = 8'd1;
        end
        @(negedge clk);
        start = 1'b0;
        len   = 8'd0;
        check_eq("done_one_cycle", 48'(done), 48'd0);
        check_eq("idle_after_done", 48'(busy), 48'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 48'(busy), 48'd0);
        check_eq({tag, "_in_ready"}, 48'(in_ready), 48'd0);
        check_eq({tag, "_res_valid"}, 48'(res_valid), 48'd0);
        check_eq({tag, "_done"}, 48'(done), 48'd0);
        check_eq({tag, "_opmode"}, 48'(dsp_opmode), 48'd0);
        check_eq({tag, "_ce_ab"}, 48'(dsp_ce_ab), 48'd0);
        check_eq({tag, "_ce_m"}, 48'(dsp_ce_m), 48'd0);
        check_eq({tag, "_ce_p"}, 48'(dsp_ce_p), 48'd0);
        check_eq({tag, "_res_data"}, res_data, 48'd0);
        check_eq({tag, "_dsp_a"}, 48'(dsp_a), 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_done;
        int snap_ab;
        int snap_m;
        int snap_p;

        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
`ifdef DSP_MAC_SCHED_STALL_CNT_EN
        check_eq("reset_stall_cnt", 48'(stall_cnt), 48'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // len=3 back-to-back: 2*3 + 4*5 + (-1)*7 = 19
        pa[0] = 18'sd2;  pb[0] = 18'sd3;
        pa[1] = 18'sd4;  pb[1] = 18'sd5;
        pa[2] = -18'sd1; pb[2] = 18'sd7;
        snap_done = n_done;
        start_job(8'd3);
        feed(3, 0);
        finish_job(48'sd19, 0, 1'b1);
        check_eq("done_count_b2b", 48'(n_done - snap_done), 48'd1);

        // Same pairs, 2-cycle gaps, result held back 5 cycles with start pulses
        snap_done = n_done;
        start_job(8'd3);
        feed(3, 2);
        finish_job(48'sd19, 5, 1'b0);
        check_eq("done_count_gap", 48'(n_done - snap_done), 48'd1);

        // len=0 goes straight to HOLD with a zero result and no slice activity
        snap_ab = n_ce_ab;
        snap_m  = n_ce_m;
        snap_p  = n_ce_p;
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check_eq("len0_res_valid", 48'(res_valid), 48'd1);
        check_eq("len0_res_data", res_data, 48'd0);
        check_eq("len0_busy", 48'(busy), 48'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("len0_done", 48'(done), 48'd1);
        @(negedge clk);
        check_eq("len0_ce_ab", 48'(n_ce_ab - snap_ab), 48'd0);
        check_eq("len0_ce_m", 48'(n_ce_m - snap_m), 48'd0);
        check_eq("len0_ce_p", 48'(n_ce_p - snap_p), 48'd0);

        // Abort after 2 of 4 accepts
        pa[0] = 18'sd5; pb[0] = 18'sd6;
        pa[1] = 18'sd7; pb[1] = 18'sd8;
        start_job(8'd4);
        feed(2, 0);
        snap_done = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("abort_no_done", 48'(n_done - snap_done), 48'd0);
        check_eq("abort_idle", 48'(busy), 48'd0);

        // Fresh len=1 job: 3 * -4 = -12
        pa[0] = 18'sd3; pb[0] = -18'sd4;
        start_job(8'd1);
        feed(1, 0);
        finish_job(-48'sd12, 0, 1'b0);

        // Full-range length: sum over i=0..254 of (i-100)*3 = 20655
        for (int i = 0; i < 255; i++) begin
            pa[i] = 18'(i - 100);
            pb[i] = 18'sd3;
        end
        start_job(8'd255);
        feed(255, 0);
        check_eq("len255_in_ready_low", 48'(in_ready), 48'd0);
        finish_job(48'sd20655, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
